// File: rtl/clk_divider_multi.sv
// Multi-channel clock/tick divider: CH independent 50%-duty enables with
// runtime half-periods that change only at a half-period boundary.
module clk_divider_multi #(
  parameter int unsigned CH_W         = 2,
  parameter int unsigned CNT_W        = 27,
  parameter int unsigned DEFAULT_HALF = 50000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 sync_clr,
  input  logic                 cfg_wr,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [CNT_W-1:0]     cfg_half,
  output logic [2**CH_W-1:0]   cfg_pending,
  output logic [2**CH_W-1:0]   clk_out,
  output logic [2**CH_W-1:0]   tick
);

  localparam int unsigned      CH       = 2**CH_W;
  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q   [CH];
  logic [CNT_W-1:0] cnt_d   [CH];
  logic [CNT_W-1:0] half_q  [CH];
  logic [CNT_W-1:0] half_d  [CH];
  logic [CNT_W-1:0] stage_q [CH];
  logic [CNT_W-1:0] stage_d [CH];
  logic [CH-1:0]    pend_q, pend_d;
  logic [CH-1:0]    out_q, out_d;
  logic [CH-1:0]    tick_q, tick_d;
  logic [CH-1:0]    wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int unsigned i = 0; i < CH; i++) begin
      wr_sel[i] = cfg_wr && (cfg_ch == CH_W'(i));
    end
  end

  // Priority per channel: sync_clr, then disabled, then normal count/freeze.
  // A write on a live channel is evaluated last so it re-arms pend even on
  // the boundary that just consumed the previous stage.
  always_comb begin
    for (int unsigned i = 0; i < CH; i++) begin
      cnt_d[i]   = cnt_q[i];
      half_d[i]  = half_q[i];
      stage_d[i] = stage_q[i];
      pend_d[i]  = pend_q[i];
      out_d[i]   = out_q[i];
      tick_d[i]  = 1'b0;
      if (sync_clr) begin
        cnt_d[i]  = '0;
        out_d[i]  = 1'b0;
        pend_d[i] = 1'b0;
        if (pend_q[i]) half_d[i] = stage_q[i];
        if (wr_sel[i]) half_d[i] = cfg_half;
      end else if (half_q[i] == '0) begin
        cnt_d[i] = '0;
        out_d[i] = 1'b0;
        if (wr_sel[i]) half_d[i] = cfg_half;
      end else begin
        if (en) begin
          if (cnt_q[i] == half_q[i] - ONE) begin
            cnt_d[i]  = '0;
            out_d[i]  = ~out_q[i];
            tick_d[i] = ~out_q[i];
            if (pend_q[i]) begin
              half_d[i] = stage_q[i];
              pend_d[i] = 1'b0;
            end
          end else begin
            cnt_d[i] = cnt_q[i] + ONE;
          end
        end
        if (wr_sel[i]) begin
          stage_d[i] = cfg_half;
          pend_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < CH; i++) begin
        cnt_q[i]   <= '0;
        half_q[i]  <= HALF_RST;
        stage_q[i] <= '0;
      end
      pend_q <= '0;
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        half_q[i]  <= half_d[i];
        stage_q[i] <= stage_d[i];
      end
      pend_q <= pend_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign cfg_pending = pend_q;
  assign clk_out     = out_q;
  assign tick        = tick_q;

endmodule

// File: tb/tb_clk_divider_multi.sv
// Bench for clk_divider_multi: directed scenarios plus random traffic, all
// checked against a countdown-based model of each channel.
module tb_clk_divider_multi;

  localparam int unsigned CH_W  = 2;
  localparam int unsigned CH    = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DEF   = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             sync_clr = 1'b0;
  logic             cfg_wr = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0;
  logic [CNT_W-1:0] cfg_half = '0;
  logic [CH-1:0]    cfg_pending, clk_out, tick;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles left until the next toggle rather than an up-counter.
  int unsigned m_half  [CH];
  int unsigned m_stage [CH];
  int unsigned m_left  [CH];
  bit          m_pend  [CH];
  bit          m_lvl   [CH];
  bit          m_tick  [CH];

  clk_divider_multi #(
    .CH_W(CH_W),
    .CNT_W(CNT_W),
    .DEFAULT_HALF(DEF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sync_clr(sync_clr),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_half(cfg_half),
    .cfg_pending(cfg_pending),
    .clk_out(clk_out),
    .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] vec_of(input bit a [CH]);
    logic [CH-1:0] v;
    for (int i = 0; i < CH; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_half[i] = DEF; m_stage[i] = 0; m_left[i] = DEF;
      m_pend[i] = 0;   m_lvl[i] = 0;   m_tick[i] = 0;
    end
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < CH; i++) begin
      bit wr;
      wr = cfg_wr && (int'(cfg_ch) == i);
      m_tick[i] = 0;
      if (sync_clr) begin
        m_lvl[i] = 0;
        if (m_pend[i]) m_half[i] = m_stage[i];
        m_pend[i] = 0;
        if (wr) m_half[i] = int'(cfg_half);
        m_left[i] = m_half[i];
      end else if (m_half[i] == 0) begin
        m_lvl[i] = 0;
        if (wr) begin
          m_half[i] = int'(cfg_half);
          m_left[i] = m_half[i];
        end
      end else begin
        if (en) begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_lvl[i]  = !m_lvl[i];
            m_tick[i] = m_lvl[i];
            if (m_pend[i]) begin
              m_half[i] = m_stage[i];
              m_pend[i] = 0;
            end
            m_left[i] = m_half[i];
          end
        end
        if (wr) begin
          m_stage[i] = int'(cfg_half);
          m_pend[i]  = 1;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("clk_out", 32'(clk_out), 32'(vec_of(m_lvl)));
    check("tick", 32'(tick), 32'(vec_of(m_tick)));
    check("cfg_pending", 32'(cfg_pending), 32'(vec_of(m_pend)));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic write(input int ch, input int h);
    cfg_wr = 1'b1; cfg_ch = CH_W'(ch); cfg_half = CNT_W'(h);
    cycle();
    cfg_wr = 1'b0;
  endtask

  initial begin
    model_reset();
    run(2);
    check("reset_out", 32'(clk_out), 32'h0);
    check("reset_pend", 32'(cfg_pending), 32'h0);

    // Steady count from reset: rises on edges 3, 9, 15
    reset = 1'b1; en = 1'b1;
    run(2); cycle();
    check("e3_tick", 32'(tick), 32'hF);
    check("e3_out", 32'(clk_out), 32'hF);
    cycle();
    check("e4_tick", 32'(tick), 32'h0);
    run(4); cycle();
    check("e9_tick", 32'(tick), 32'hF);
    run(5); cycle();
    check("e15_tick", 32'(tick), 32'hF);

    // Reprogram ch1 to 5 at cnt=0; old half-period still 3 cycles
    write(1, 5);
    check("reprog_pend", 32'(cfg_pending), 32'h2);
    run(1); cycle();
    check("e18_out", 32'(clk_out), 32'h0);
    check("e18_pend", 32'(cfg_pending), 32'h0);
    run(4); cycle();
    check("e23_out", 32'(clk_out), 32'hF);
    check("e23_tick", 32'(tick), 32'h2);

    // Disable ch2, then reload it directly
    write(2, 0);
    run(10);
    check("dis_out2", 32'(clk_out[2]), 32'h0);
    write(2, 4);
    check("dis_load_pend", 32'(cfg_pending[2]), 32'h0);
    run(12);

    // Freeze, then write collision on ch0 boundary
    en = 1'b0;
    run(10);
    en = 1'b1;
    for (int k = 0; k < 20 && m_left[0] != 2; k++) cycle();
    check("wait_ch0_bound", 32'(m_left[0]), 32'd2);
    write(0, 2);
    write(0, 4);
    check("collide_pend0", 32'(cfg_pending[0]), 32'h1);
    run(20);

    // sync_clr with ch3 pending 7
    write(3, 7);
    sync_clr = 1'b1;
    cycle();
    sync_clr = 1'b0;
    check("sclr_out", 32'(clk_out), 32'h0);
    check("sclr_pend", 32'(cfg_pending), 32'h0);
    run(30);

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    check("areset_out", 32'(clk_out), 32'h0);
    check("areset_tick", 32'(tick), 32'h0);
    check("areset_pend", 32'(cfg_pending), 32'h0);
    model_reset();
    #2 reset = 1'b1;
    run(10);

    // Random traffic
    repeat (3000) begin
      en       = ($urandom_range(0, 9) != 0);
      sync_clr = ($urandom_range(0, 59) == 0);
      cfg_wr   = ($urandom_range(0, 11) == 0);
      cfg_ch   = CH_W'($urandom_range(0, CH - 1));
      cfg_half = ($urandom_range(0, 7) == 0) ? '0 : CNT_W'($urandom_range(1, 6));
      cycle();
    end
    en = 1'b0; sync_clr = 1'b0; cfg_wr = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
